squeeze_feed: RTL and testbench

SQUEEZE_FEED -- requirements
Module: squeeze_feed

---
 rtl/squeeze_feed.sv | 105 ++++++++++
 tb/tb_squeeze_feed.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/squeeze_feed.sv
// Buffers SHAKE128 rate blocks and feeds their 21 lanes, one 64-bit word per request, to the parser.
// Define SQZ_PINGPONG_EN for two block buffers (back-to-back streaming); default build uses one buffer.
module squeeze_feed (
    input  logic          clk,
    input  logic          resetb,
    input  logic          blk_valid,
    input  logic [1343:0] blk_data,
    output logic          blk_ready,
    input  logic          gimme,
    input  logic          done,
    output logic [63:0]   out,
    output logic          out_valid,
    output logic [4:0]    lane_idx,
    output logic [7:0]    word_cnt
);

`ifdef SQZ_PINGPONG_EN
    localparam int unsigned NBUF = 2;
`else
    localparam int unsigned NBUF = 1;
`endif
    localparam logic [4:0] LAST_LANE = 5'd20;

    logic [1343:0]   blk_mem [NBUF];
    logic [NBUF-1:0] full;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [4:0]      rd_idx;
    logic            accept;
    logic            emit;
    logic            last_lane;
    logic [1343:0]   rd_blk;
    logic [63:0]     rd_lane;

    // The write pointer always lands on the oldest free buffer, so one flag decides readiness.
    always_comb begin
        blk_ready = !resetb && !done && !full[wr_ptr];
        accept    = blk_valid && blk_ready;
        emit      = !resetb && !done && gimme && full[rd_ptr];
        last_lane = (rd_idx == LAST_LANE);
        rd_blk    = blk_mem[rd_ptr];
        rd_lane   = rd_blk[rd_idx*64 +: 64];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            blk_mem[wr_ptr] <= blk_data;
        end
    end

`ifdef SQZ_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (resetb || done) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (emit && last_lane) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end
`else
    always_comb begin
        wr_ptr = 1'b0;
        rd_ptr = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (resetb) begin
            out       <= '0;
            out_valid <= 1'b0;
            lane_idx  <= '0;
            word_cnt  <= '0;
            rd_idx    <= '0;
            full      <= '0;
        end else if (done) begin
            out_valid <= 1'b0;
            word_cnt  <= '0;
            rd_idx    <= '0;
            full      <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out      <= rd_lane;
                lane_idx <= rd_idx;
                word_cnt <= word_cnt + 8'd1;
                if (last_lane) begin
                    rd_idx       <= '0;
                    full[rd_ptr] <= 1'b0;
                end else begin
                    rd_idx <= rd_idx + 5'd1;
                end
            end
            // In ping-pong mode a same-cycle accept targets the other buffer, so set and clear never collide.
            if (accept) begin
                full[wr_ptr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_squeeze_feed.sv
// Self-checking bench for squeeze_feed: directed scenarios plus random traffic against a block-queue model.
// Honors SQZ_PINGPONG_EN to size the model's buffer capacity.
module tb_squeeze_feed;

`ifdef SQZ_PINGPONG_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          resetb;
    logic          blk_valid;
    logic [1343:0] blk_data;
    logic          blk_ready;
    logic          gimme;
    logic          done;
    logic [63:0]   out;
    logic          out_valid;
    logic [4:0]    lane_idx;
    logic [7:0]    word_cnt;

    squeeze_feed dut (
        .clk       (clk),
        .resetb    (resetb),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_ready (blk_ready),
        .gimme     (gimme),
        .done      (done),
        .out       (out),
        .out_valid (out_valid),
        .lane_idx  (lane_idx),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: blocks held by the DUT, oldest first; lanes drain from the head block.
    logic [1343:0] mq[$];
    logic [1343:0] pend[$];
    int unsigned   m_idx = 0;
    logic [63:0]   m_out = '0;
    logic [4:0]    m_lane = '0;
    logic [7:0]    m_cnt = '0;
    logic          m_ov = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1343:0] make_block(input logic [63:0] base);
        logic [1343:0] b;
        for (int k = 0; k < 21; k++) b[64*k +: 64] = base + 64'(k);
        return b;
    endfunction

    function automatic logic [1343:0] rand_block();
        logic [1343:0] b;
        for (int k = 0; k < 42; k++) b[32*k +: 32] = $urandom();
        return b;
    endfunction

    task automatic cycle(input logic r, input logic g, input logic d);
        logic          exp_ready;
        logic          acc;
        logic [1343:0] head;
        resetb    = r;
        gimme     = g;
        done      = d;
        blk_valid = (pend.size() > 0);
        blk_data  = blk_valid ? pend[0] : rand_block();
        #1;
        exp_ready = !r && !d && (mq.size() < CAP);
        check("blk_ready", {63'd0, blk_ready}, {63'd0, exp_ready});
        acc = blk_valid && exp_ready;
        if (r) begin
            mq.delete();
            m_idx = 0; m_out = '0; m_lane = '0; m_cnt = '0; m_ov = 1'b0;
        end else if (d) begin
            mq.delete();
            m_idx = 0; m_cnt = '0; m_ov = 1'b0;
        end else begin
            m_ov = g && (mq.size() > 0);
            if (m_ov) begin
                head   = mq[0];
                m_out  = head[64*m_idx +: 64];
                m_lane = 5'(m_idx);
                m_cnt  = m_cnt + 8'd1;
                m_idx++;
                if (m_idx == 21) begin
                    void'(mq.pop_front());
                    m_idx = 0;
                end
            end
            if (acc) mq.push_back(blk_data);
        end
        if (acc) void'(pend.pop_front());
        @(posedge clk);
        #1;
        check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        check("out", out, m_out);
        check("lane_idx", {59'd0, lane_idx}, {59'd0, m_lane});
        check("word_cnt", {56'd0, word_cnt}, {56'd0, m_cnt});
        @(negedge clk);
    endtask

    initial begin
        resetb = 1'b1; gimme = 1'b0; done = 1'b0; blk_valid = 1'b0; blk_data = '0;
        @(negedge clk);
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        check("reset_out", out, 64'd0);
        check("reset_cnt", {56'd0, word_cnt}, 64'd0);

        // Single block drained with gimme held
        pend.push_back(make_block(64'h1000));
        cycle(0, 0, 0);
        for (int i = 0; i < 21; i++) cycle(0, 1, 0);
        check("blk_out_last", out, 64'h1014);
        check("blk_lane_last", {59'd0, lane_idx}, 64'd20);
        check("blk_word_cnt", {56'd0, word_cnt}, 64'd21);
        cycle(0, 0, 0);
        check("blk_ready_after", {63'd0, blk_ready}, 64'd1);

        // Stalling gimme
        pend.push_back(make_block(64'h2000));
        cycle(0, 0, 0);
        for (int i = 0; i < 44; i++) cycle(0, (i % 2) == 0, 0);

        // Two blocks back-to-back with gimme held
        pend.push_back(make_block(64'hA00));
        pend.push_back(make_block(64'hB00));
        for (int i = 0; i < 50; i++) cycle(0, 1, 0);

        // Flush after 10 words
        pend.push_back(make_block(64'h3000));
        pend.push_back(make_block(64'h4000));
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0);
        pend.push_back(make_block(64'h5000));
        cycle(0, 1, 1);
        check("flush_cnt", {56'd0, word_cnt}, 64'd0);
        cycle(0, 1, 1);
        pend.delete();
        pend.push_back(make_block(64'h6000));
        for (int i = 0; i < 25; i++) cycle(0, 1, 0);

        // Reset after lane 5
        pend.push_back(make_block(64'h7000));
        cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0);
        pend.push_back(make_block(64'h8000));
        cycle(1, 1, 1);
        check("midreset_out", out, 64'd0);
        for (int i = 0; i < 25; i++) cycle(0, 1, 0);

        // Requests with nothing buffered
        for (int i = 0; i < 10; i++) cycle(0, 1, 0);
        check("empty_cnt", {63'd0, out_valid}, 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (pend.size() < 2 && $urandom_range(0, 3) == 0) pend.push_back(rand_block());
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 79) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
